// File: rtl/feature_cache_reader.sv
// Purpose: read-side master for the feature cache. A start command walks a
// contiguous (wrapping) address range of the cache read port and streams the
// words out over a valid/ready interface with full backpressure.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, base_addr,     job command; base/count sampled when start is accepted
//   count
//   abort                 synchronous flush of the current job (no done pulse)
//   busy, done            job in progress / 1-cycle completion pulse
//   raddr, q              cache read port (q valid the cycle after raddr)
//   out_data, out_valid,  output stream, out_last marks the final word
//   out_ready, out_last
module feature_cache_reader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [WORD_SIZE-1:0]  q,
  output logic [WORD_SIZE-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned RCNT_W = ADDR_WIDTH + 1;
  localparam int unsigned ENT_W  = WORD_SIZE + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [RCNT_W-1:0]     r_remaining;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_last_issue;
  logic [CNT_W-1:0]      w_occ;
  logic [ENT_W-1:0]      w_head;

  // FIFO head drives the stream directly
  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_cnt != '0);
  assign out_data  = w_head[WORD_SIZE-1:0];
  assign out_last  = out_valid & w_head[WORD_SIZE];
  assign busy      = r_busy;
  assign done      = r_done;

  assign w_pop  = out_valid & out_ready;
  assign w_push = r_inflight;

  // Occupancy the FIFO will have once the in-flight word lands, net of this cycle's pop
  assign w_occ = r_cnt + CNT_W'(r_inflight) - CNT_W'(w_pop);

  assign w_issue = (r_state == S_READ) && !reset && !abort &&
                   (r_remaining != '0) && (w_occ < CNT_W'(FIFO_DEPTH));
  assign w_last_issue = w_issue && (r_remaining == RCNT_W'(1));

  // Address is presented in the issue cycle so the RAM's own address register
  // captures it; between issues the last issued address is held.
  assign raddr = w_issue ? r_next_addr : r_raddr;

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (w_last_issue) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as the last word is accepted so done follows it by one cycle
        if (!r_inflight && ((r_cnt == '0) || ((r_cnt == CNT_W'(1)) && w_pop))) begin
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (abort) begin
      w_next_state = S_IDLE;
    end
  end

  // State register with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= (w_next_state == S_DONE);
    end
  end

  // Read issue, in-flight tracking and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_raddr         <= '0;
      r_next_addr     <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_cnt           <= '0;
    end else if (abort) begin
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_cnt           <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_next_addr <= base_addr;
        r_remaining <= count;
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;
      if (w_issue) begin
        r_raddr     <= r_next_addr;
        r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - RCNT_W'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // FIFO storage: returning read data tagged with its last-word flag
  always_ff @(posedge clk) begin
    if (w_push && !reset && !abort) begin
      r_mem[r_wr_ptr] <= {r_inflight_last, q};
    end
  end

endmodule

// File: tb/tb_feature_cache_reader.sv
// Purpose: self-checking bench for feature_cache_reader. Table-driven jobs
// (base, count, ready pattern, hand-computed done cycle and final raddr) plus
// hand-written abort and reset sequences. A behavioural 1-cycle-latency RAM
// holds cache[i] = i+1.
module tb_feature_cache_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic        abort;
  logic        busy;
  logic        done;
  logic [9:0]  raddr;
  logic [7:0]  q;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [1024];

  always #5 clk = ~clk;

  always @(posedge clk) q <= mem[raddr];

  feature_cache_reader #(.ADDR_WIDTH(10), .WORD_SIZE(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .count(count), .abort(abort), .busy(busy), .done(done), .raddr(raddr),
    .q(q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  typedef struct {
    logic [9:0]  base;
    logic [10:0] cnt;
    int          pat;        // 0 always ready, 1 toggle, 2 toggle + 10-cycle stall
    int          spur_k;     // cycle of an extra start while busy, -1 none
    int          exp_done;   // cycle of the done pulse, -1 when not hand-computed
    logic [9:0]  exp_raddr;  // raddr held after the job
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_word(input logic [9:0] base, input int k);
    logic [9:0] a;
    a = base + 10'(k);
    return 8'(a) + 8'd1;
  endfunction

  function automatic logic ready_of(input int pat, input int k);
    if (pat == 0) return 1'b1;
    if (pat == 1) return k[0];
    if (k < 20) return k[0];
    if (k < 30) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_job(input vec_t v);
    int nacc = 0;
    int ndone = 0;
    int done_k = -1;
    int first_acc = -1;
    int last_acc = -1;
    int first_valid = -1;
    int budget;
    logic hold = 1'b0;
    logic [7:0] hdata = '0;
    logic hlast = 1'b0;
    logic [9:0] r24 = '0;
    budget = int'(v.cnt) * 3 + 60;
    @(negedge clk);
    base_addr = v.base;
    count     = v.cnt;
    out_ready = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = 10'h3ff;
    count     = 11'd3;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      out_ready = ready_of(v.pat, k);
      start = (k == v.spur_k);
      if (start) begin
        base_addr = 10'd900;
        count     = 11'd3;
      end
      #1;
      if (hold) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(hdata));
        chk("stall_last", 32'(out_last), 32'(hlast));
        hold = 1'b0;
      end
      if (out_valid && first_valid < 0) first_valid = k;
      if (out_valid && out_ready) begin
        chk("word_data", 32'(out_data), 32'(exp_word(v.base, nacc)));
        chk("word_last", 32'(out_last), 32'(nacc == int'(v.cnt) - 1));
        if (first_acc < 0) first_acc = k;
        last_acc = k;
        nacc++;
      end else if (out_valid) begin
        hold  = 1'b1;
        hdata = out_data;
        hlast = out_last;
      end
      if (done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (v.pat == 2 && k == 24) r24 = raddr;
      if (v.pat == 2 && k == 29) begin
        chk("full_raddr_hold", 32'(raddr), 32'(r24));
        chk("full_valid", 32'(out_valid), 32'd1);
      end
      if (done_k >= 0 && k == done_k + 2) break;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    if (done_k < 0) chk("done_timeout", 32'd0, 32'd1);
    chk("word_count", 32'(nacc), 32'(v.cnt));
    chk("done_pulses", 32'(ndone), 32'd1);
    if (v.cnt != '0) begin
      chk("done_after_last", 32'(done_k), 32'(last_acc + 1));
      chk("first_valid_ge2", 32'(first_valid >= 2), 32'd1);
    end else begin
      chk("no_valid", 32'(first_valid), 32'(-1));
    end
    if (v.exp_done >= 0) chk("done_cycle", 32'(done_k), 32'(v.exp_done));
    if (v.pat == 0 && v.cnt != '0)
      chk("consecutive", 32'(last_acc - first_acc), 32'(int'(v.cnt) - 1));
    chk("busy_after", 32'(busy), 32'd0);
    chk("raddr_after", 32'(raddr), 32'(v.exp_raddr));
  endtask

  initial begin
    bit saw;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i + 1);

    vecs[0] = '{base: 10'd5,    cnt: 11'd8,    pat: 0, spur_k: -1, exp_done: 11,   exp_raddr: 10'd12};
    vecs[1] = '{base: 10'd100,  cnt: 11'd16,   pat: 2, spur_k: -1, exp_done: -1,   exp_raddr: 10'd115};
    vecs[2] = '{base: 10'd1022, cnt: 11'd4,    pat: 0, spur_k: -1, exp_done: 7,    exp_raddr: 10'd1};
    vecs[3] = '{base: 10'd7,    cnt: 11'd0,    pat: 0, spur_k: -1, exp_done: 1,    exp_raddr: 10'd1};
    vecs[4] = '{base: 10'd300,  cnt: 11'd1,    pat: 0, spur_k: -1, exp_done: 4,    exp_raddr: 10'd300};
    vecs[5] = '{base: 10'd0,    cnt: 11'd1024, pat: 0, spur_k: -1, exp_done: 1027, exp_raddr: 10'd1023};
    vecs[6] = '{base: 10'd1020, cnt: 11'd9,    pat: 1, spur_k: 5,  exp_done: -1,   exp_raddr: 10'd4};

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    base_addr = '0; count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // Abort in DRAIN with 3 words buffered; a simultaneous start must lose
    @(negedge clk);
    base_addr = 10'd200; count = 11'd3; out_ready = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_abort_valid", 32'(out_valid), 32'd1);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    abort = 1'b1; start = 1'b1; base_addr = 10'd600; count = 11'd2;
    @(posedge clk);
    #1 abort = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || out_valid || busy) saw = 1'b1;
    end
    chk("abort_quiet", 32'(saw), 32'd0);
    run_job('{base: 10'd200, cnt: 11'd3, pat: 0, spur_k: -1, exp_done: 6, exp_raddr: 10'd202});

    // Reset asserted mid-READ
    @(negedge clk);
    base_addr = 10'd400; count = 11'd20; out_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_last", 32'(out_last), 32'd0);
    chk("midrst_raddr", 32'(raddr), 32'd0);
    out_ready = 1'b0;
    run_job('{base: 10'd10, cnt: 11'd5, pat: 0, spur_k: -1, exp_done: 8, exp_raddr: 10'd14});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
